ex_stage: RTL and testbench

Execute stage of the five-stage MIPS-style pipeline, between the ID/EX and EX/MEM pipeline buses. It takes the 181-bit ID/EX bundle and performs the ALU operation. It resolves branch and jump targets and conditions, then registers a 141-bit EX/MEM bundle on the rising clock edge for the MEM stage.

---
 rtl/ex_stage.sv | 148 ++++++++++++++
 tb/tb_ex_stage.sv | 137 +++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - Execute stage: ALU, branch/jump resolution, EX/MEM register.
module ex_stage (
    input  logic         CLK,
    input  logic         RST,
    input  logic [180:0] IDEX,
    output logic [140:0] exmem
);

    logic [31:0] w_pc_plus_4;
    logic [31:0] w_rs_data;
    logic [31:0] w_rt_data;
    logic [31:0] w_imm;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [4:0]  w_shamt;
    logic [4:0]  w_alu_op;
    logic        w_valid;
    logic        w_reg_write;
    logic        w_mem_read;
    logic        w_mem_write;
    logic        w_mem_to_reg;
    logic        w_alu_src;
    logic        w_reg_dst;
    logic        w_beq;
    logic        w_bne;
    logic        w_j;
    logic        w_jal;
    logic        w_jr;

    assign w_pc_plus_4  = IDEX[31:0];
    assign w_rs_data    = IDEX[63:32];
    assign w_rt_data    = IDEX[95:64];
    assign w_imm        = IDEX[127:96];
    assign w_rt         = IDEX[132:128];
    assign w_rd         = IDEX[137:133];
    assign w_shamt      = IDEX[142:138];
    assign w_alu_op     = IDEX[147:143];
    assign w_valid      = IDEX[148];
    assign w_reg_write  = IDEX[149];
    assign w_mem_read   = IDEX[150];
    assign w_mem_write  = IDEX[151];
    assign w_mem_to_reg = IDEX[152];
    assign w_alu_src    = IDEX[153];
    assign w_reg_dst    = IDEX[154];
    assign w_beq        = IDEX[155];
    assign w_bne        = IDEX[156];
    assign w_j          = IDEX[157];
    assign w_jal        = IDEX[158];
    assign w_jr         = IDEX[159];

    logic [31:0] w_op_b;
    logic [31:0] w_alu;
    logic [4:0]  w_var_sh;

    assign w_op_b   = w_alu_src ? w_imm : w_rt_data;
    assign w_var_sh = w_rs_data[4:0];

    // Shifts always take rt_data as the source, independent of alu_src.
    always_comb begin
        w_alu = 32'd0;
        case (w_alu_op)
            5'd0, 5'd1: w_alu = w_rs_data + w_op_b;
            5'd2, 5'd3: w_alu = w_rs_data - w_op_b;
            5'd4:       w_alu = w_rs_data & w_op_b;
            5'd5:       w_alu = w_rs_data | w_op_b;
            5'd6:       w_alu = w_rs_data ^ w_op_b;
            5'd7:       w_alu = ~(w_rs_data | w_op_b);
            5'd8:       w_alu = {31'd0, $signed(w_rs_data) < $signed(w_op_b)};
            5'd9:       w_alu = {31'd0, w_rs_data < w_op_b};
            5'd10:      w_alu = w_rt_data << w_shamt;
            5'd11:      w_alu = w_rt_data >> w_shamt;
            5'd12:      w_alu = $unsigned($signed(w_rt_data) >>> w_shamt);
            5'd13:      w_alu = w_rt_data << w_var_sh;
            5'd14:      w_alu = w_rt_data >> w_var_sh;
            5'd15:      w_alu = $unsigned($signed(w_rt_data) >>> w_var_sh);
            5'd16:      w_alu = {w_imm[15:0], 16'd0};
            default:    w_alu = 32'd0;
        endcase
    end

    logic        w_eq;
    logic [31:0] w_br_target;
    logic [31:0] w_j_target;
    logic [31:0] w_target;
    logic        w_taken;
    logic        w_jump;

    assign w_eq        = (w_rs_data == w_rt_data);
    assign w_br_target = w_pc_plus_4 + {w_imm[29:0], 2'b00};
    assign w_j_target  = {w_pc_plus_4[31:28], w_imm[25:0], 2'b00};

    // Flow-control priority: jr > jal > j > beq > bne.
    always_comb begin
        w_target = 32'd0;
        w_taken  = 1'b0;
        w_jump   = 1'b0;
        if (w_jr) begin
            w_jump   = 1'b1;
            w_target = w_rs_data;
        end else if (w_jal || w_j) begin
            w_jump   = 1'b1;
            w_target = w_j_target;
        end else if (w_beq) begin
            w_taken  = w_eq;
            w_target = w_br_target;
        end else if (w_bne) begin
            w_taken  = ~w_eq;
            w_target = w_br_target;
        end
    end

    logic [31:0] w_result;
    logic [4:0]  w_dest;

    assign w_result = w_jal ? w_pc_plus_4 : w_alu;
    assign w_dest   = w_jal ? 5'd31 : (w_reg_dst ? w_rd : w_rt);

    logic [140:0] w_next;

    assign w_next = {
        w_pc_plus_4,
        w_valid,
        (w_alu == 32'd0),
        w_jump & w_valid,
        w_mem_to_reg,
        w_mem_write & w_valid,
        w_mem_read & w_valid,
        w_reg_write & w_valid,
        w_taken & w_valid,
        w_target,
        w_dest,
        w_rt_data,
        w_result
    };

    logic [140:0] r_exmem;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_exmem <= '0;
        end else begin
            r_exmem <= w_next;
        end
    end

    assign exmem = r_exmem;

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - Directed self-checking bench for ex_stage.
module tb_ex_stage;

    logic         CLK;
    logic         RST;
    logic [180:0] IDEX;
    logic [140:0] exmem;

    ex_stage dut (
        .CLK   (CLK),
        .RST   (RST),
        .IDEX  (IDEX),
        .exmem (exmem)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int passed;
    int total;

    logic [31:0] pc, rs, rtd, imm;
    logic [4:0]  rt, rd, shamt, aluop;
    logic        valid, regw, memr, memw, m2r, asrc, rdst, beq, bne, jj, jal, jr;

    task automatic defaults();
        pc = 32'h0; rs = 32'h0; rtd = 32'h0; imm = 32'h0;
        rt = 5'd0; rd = 5'd0; shamt = 5'd0; aluop = 5'd0;
        valid = 1'b1; regw = 1'b0; memr = 1'b0; memw = 1'b0; m2r = 1'b0;
        asrc = 1'b0; rdst = 1'b0; beq = 1'b0; bne = 1'b0; jj = 1'b0; jal = 1'b0; jr = 1'b0;
    endtask

    task automatic apply();
        @(negedge CLK);
        IDEX = {21'd0, jr, jal, jj, bne, beq, rdst, asrc, m2r, memw, memr, regw, valid,
                aluop, shamt, rd, rt, imm, rtd, rs, pc};
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [140:0] obs, input logic [140:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        passed = 0;
        total  = 0;
        RST    = 1'b0;
        IDEX   = '1;
        #3;
        RST = 1'b1;
        #1;
        chk("reset_immediate", exmem, 141'd0);
        @(posedge CLK); @(posedge CLK); #1;
        chk("reset_held", exmem, 141'd0);
        @(negedge CLK);
        RST = 1'b0;

        defaults(); rs = 32'h7FFFFFFF; rtd = 32'h1; aluop = 5'd0; apply();
        chk("add_result", exmem[31:0], 32'h80000000);
        chk("add_zero", exmem[107], 1'b0);
        chk("valid", exmem[108], 1'b1);

        defaults(); rs = 32'd5; rtd = 32'd5; aluop = 5'd2; apply();
        chk("sub_result", exmem[31:0], 32'h0);
        chk("sub_zero", exmem[107], 1'b1);

        defaults(); rs = 32'hFFFFFFFF; rtd = 32'h1; aluop = 5'd8; apply();
        chk("slt", exmem[31:0], 32'h1);
        defaults(); rs = 32'hFFFFFFFF; rtd = 32'h1; aluop = 5'd9; apply();
        chk("sltu", exmem[31:0], 32'h0);

        defaults(); rtd = 32'h80000000; shamt = 5'd4; aluop = 5'd12; apply();
        chk("sra", exmem[31:0], 32'hF8000000);

        defaults(); asrc = 1'b1; imm = 32'h1234; aluop = 5'd16; apply();
        chk("lui", exmem[31:0], 32'h12340000);

        defaults(); rs = 32'hFFFF; rtd = 32'h1; aluop = 5'd20; apply();
        chk("undefined_op", exmem[31:0], 32'h0);

        defaults(); pc = 32'h100; imm = 32'hFFFFFFFE; rs = 32'd7; rtd = 32'd7; beq = 1'b1; apply();
        chk("beq_taken", exmem[101], 1'b1);
        chk("beq_target", exmem[100:69], 32'h000000F8);
        chk("beq_jump", exmem[106], 1'b0);

        defaults(); pc = 32'h100; imm = 32'hFFFFFFFE; rs = 32'd7; rtd = 32'd7; bne = 1'b1; apply();
        chk("bne_taken", exmem[101], 1'b0);

        defaults(); pc = 32'h40000004; imm = 32'h10; jal = 1'b1; apply();
        chk("jal_jump", exmem[106], 1'b1);
        chk("jal_target", exmem[100:69], 32'h40000040);
        chk("jal_dest", exmem[68:64], 5'd31);
        chk("jal_link", exmem[31:0], 32'h40000004);

        defaults(); pc = 32'h40000004; rs = 32'h1000; jr = 1'b1; apply();
        chk("jr_jump", exmem[106], 1'b1);
        chk("jr_target", exmem[100:69], 32'h1000);

        defaults(); valid = 1'b0; regw = 1'b1; memw = 1'b1; beq = 1'b1; rs = 32'd3; rtd = 32'd3; apply();
        chk("bubble_flags", {exmem[108], exmem[102], exmem[104], exmem[101], exmem[106]}, 5'b00000);

        defaults(); rdst = 1'b1; rd = 5'd9; rt = 5'd3; rtd = 32'hDEADBEEF;
        memr = 1'b1; memw = 1'b1; m2r = 1'b1; regw = 1'b1; pc = 32'h00ABCDE0; apply();
        chk("dest_rd", exmem[68:64], 5'd9);
        chk("store_data", exmem[63:32], 32'hDEADBEEF);
        chk("ctrl_echo", {exmem[105], exmem[104], exmem[103], exmem[102]}, 4'b1111);
        chk("pc_pass", exmem[140:109], 32'h00ABCDE0);
        chk("no_flow_target", {exmem[100:69], exmem[101], exmem[106]}, 34'd0);

        // Mid-cycle IDEX change must not disturb the registered output.
        #2;
        IDEX[68:64] = 5'd0;
        IDEX[154]   = 1'b0;
        #1;
        chk("hold_between_edges", exmem[68:64], 5'd9);

        defaults(); rdst = 1'b0; rd = 5'd9; rt = 5'd3; apply();
        chk("dest_rt", exmem[68:64], 5'd3);

        defaults(); regw = 1'b1; rs = 32'd1; rtd = 32'd2; apply();
        #1;
        RST = 1'b1;
        #1;
        chk("reset_midstream", exmem, 141'd0);
        @(negedge CLK);
        RST = 1'b0;
        defaults(); rs = 32'd10; rtd = 32'd3; aluop = 5'd3; apply();
        chk("after_reset_subu", exmem[31:0], 32'd7);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
